// File: rtl/pixel_read_server.sv
// pixel_read_server
//   Responder for (X,Y) pixel read requests. Each accepted request is mapped
//   to a linear SRAM word address (Y*IMG_W + X), the read-only SRAM port is
//   driven, and the 10-bit pixel returned SRAM_LAT cycles later is queued in
//   a show-ahead response FIFO. Responses leave strictly in accept order.
//   Out-of-bounds requests still occupy a slot and return data 0 with oob set.
//   Requests are credit-limited so the FIFO can never overflow even when the
//   consumer stalls.
//
// Ports
//   iCLK, iRST          clock, asynchronous active-high reset
//   iReq_valid/oReq_ready, iX, iY   request handshake and coordinates
//   oSRAM_ADDR, oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, iSRAM_DQ   SRAM read port
//   oRsp_valid/iRsp_ready, oRsp_data, oRsp_oob   response handshake (FIFO head)
//   oBusy               a request is in flight or a response is queued
module pixel_read_server #(
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 384,
    parameter int ADDR_W     = 18,
    parameter int SRAM_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iReq_valid,
    output logic              oReq_ready,
    input  logic [12:0]       iX,
    input  logic [12:0]       iY,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic              oSRAM_CE_N,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_WE_N,
    input  logic [15:0]       iSRAM_DQ,
    output logic              oRsp_valid,
    input  logic              iRsp_ready,
    output logic [9:0]        oRsp_data,
    output logic              oRsp_oob,
    output logic              oBusy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [12:0]    IMG_W_C = 13'(IMG_W);
    localparam logic [12:0]    IMG_H_C = 13'(IMG_H);

    logic [CNT_W-1:0]    fifoCount;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W:0]      creditUsed;
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W-1:0]    rdPtr;
    logic [10:0]         fifoMem [FIFO_DEPTH];
    logic [10:0]         fifoHead;
    logic [10:0]         wrEntry;
    logic [SRAM_LAT-1:0] tagVld;
    logic [SRAM_LAT-1:0] tagOob;
    logic                accept;
    logic                fifoWr;
    logic                fifoRd;
    logic                reqOob;
    logic [25:0]         linearAddr;
    logic                unusedBits;

    // Credit: every accepted request owns a FIFO slot from accept until pop,
    // so in-flight plus queued may never exceed the FIFO depth.
    assign creditUsed = {1'b0, fifoCount} + {1'b0, inflight};
    assign oReq_ready = !iRST && (creditUsed < DEPTH_C);
    assign accept     = iReq_valid && oReq_ready;

    // Full 26-bit product so large coordinates are judged before truncation.
    assign linearAddr = 26'(iY) * 26'(IMG_W) + 26'(iX);
    assign reqOob     = (iX >= IMG_W_C) || (iY >= IMG_H_C);
    assign unusedBits = ^{iSRAM_DQ[15:10], linearAddr[25:ADDR_W]};

    // Stage 0: address launch on accept
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oSRAM_ADDR <= '0;
            oSRAM_CE_N <= 1'b1;
            oSRAM_OE_N <= 1'b1;
        end else begin
            oSRAM_CE_N <= 1'b0;
            oSRAM_OE_N <= 1'b0;
            if (accept) begin
                oSRAM_ADDR <= reqOob ? '0 : linearAddr[ADDR_W-1:0];
            end
        end
    end

    assign oSRAM_WE_N = 1'b1;

    // Stage 1..SRAM_LAT: tag travels alongside the SRAM access
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            tagVld <= '0;
            tagOob <= '0;
        end else begin
            tagVld[0] <= accept;
            tagOob[0] <= reqOob;
            for (int i = 1; i < SRAM_LAT; i++) begin
                tagVld[i] <= tagVld[i-1];
                tagOob[i] <= tagOob[i-1];
            end
        end
    end

    // Stage SRAM_LAT: DQ sampled into the response FIFO
    assign fifoWr  = tagVld[SRAM_LAT-1];
    assign wrEntry = tagOob[SRAM_LAT-1] ? 11'h400 : {1'b0, iSRAM_DQ[9:0]};
    assign fifoRd  = oRsp_valid && iRsp_ready;

    always_ff @(posedge iCLK) begin
        if (fifoWr) begin
            fifoMem[wrPtr] <= wrEntry;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            inflight  <= '0;
        end else begin
            if (fifoWr) wrPtr <= wrPtr + PTR_W'(1);
            if (fifoRd) rdPtr <= rdPtr + PTR_W'(1);
            case ({fifoWr, fifoRd})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
            case ({accept, fifoWr})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Head is gated so the outputs read 0 whenever the FIFO is empty,
    // including directly out of reset when the storage is undefined.
    assign fifoHead   = fifoMem[rdPtr];
    assign oRsp_valid = (fifoCount != '0);
    assign oRsp_data  = oRsp_valid ? fifoHead[9:0] : 10'd0;
    assign oRsp_oob   = oRsp_valid ? fifoHead[10] : 1'b0;
    assign oBusy      = (inflight != '0) || (fifoCount != '0);

endmodule

// File: doc/pixel_read_server.md
Name: pixel_read_server

Overview:
- Responder side of the pixel-fetch interface used by the correlation scorer: accepts (X,Y) pixel read requests, maps them to a linear SRAM word address, drives the read-only SRAM port and returns 10-bit pixel data in request order.
- Sits between the image SRAM (one pixel per 16-bit word, pixel in DQ[9:0]) and any coordinate-generating consumer (correlation/score engines).
- Credit-limited pipeline with a small response FIFO so consumers may stall without losing data.

Parameters:
- IMG_W, 512, image width in pixels; valid X is 0..IMG_W-1
- IMG_H, 384, image height in lines; valid Y is 0..IMG_H-1
- ADDR_W, 18, SRAM word address width
- SRAM_LAT, 2, cycles from address launch edge to DQ sample edge (1..4)
- FIFO_DEPTH, 4, response FIFO entries (power of 2, 2..16)

Ports:
- iCLK  in  1  system clock
- iRST  in  1  reset, asynchronous, active-high
- iReq_valid  in  1  request present
- oReq_ready  out  1  request accepted this cycle when high together with iReq_valid
- iX  in  13  request X coordinate
- iY  in  13  request Y coordinate
- oSRAM_ADDR  out  ADDR_W  SRAM word address
- oSRAM_CE_N  out  1  SRAM chip enable, active-low
- oSRAM_OE_N  out  1  SRAM output enable, active-low
- oSRAM_WE_N  out  1  SRAM write enable, held high (never writes)
- iSRAM_DQ  in  16  SRAM read data
- oRsp_valid  out  1  response available at FIFO head
- iRsp_ready  in  1  consumer takes response when high with oRsp_valid
- oRsp_data  out  10  pixel value; 0 for out-of-bounds requests
- oRsp_oob  out  1  response belongs to an out-of-bounds request
- oBusy  out  1  any request in flight or any FIFO entry occupied

Behaviour:
- Reset (async assert, sync-released by the flop clocking): oReq_ready=0 while iRST high, oRsp_valid=0, oRsp_data=0, oRsp_oob=0, oSRAM_ADDR=0, oSRAM_CE_N=1, oSRAM_OE_N=1, oSRAM_WE_N=1, oBusy=0; FIFO pointers, in-flight counter and tag shift register cleared. Reset mid-operation discards all in-flight and queued responses; none appear after release.
- After reset: oSRAM_CE_N=0, oSRAM_OE_N=0 permanently; WE_N stays 1.
- Accept: handshake at edge E0 when iReq_valid & oReq_ready. oReq_ready = !iRST & (fifo_count + inflight < FIFO_DEPTH); derived from registers only, never from iReq_valid or iRsp_ready.
- Address: on E0, oSRAM_ADDR <= iY*IMG_W + iX truncated to ADDR_W; oob = (iX >= IMG_W) | (iY >= IMG_H); for oob, oSRAM_ADDR <= 0. Without accept, oSRAM_ADDR holds.
- Pipeline: valid/oob tag shifts SRAM_LAT stages; at edge E0+SRAM_LAT, iSRAM_DQ[9:0] (or 0 if oob) and oob bit written to FIFO. oRsp_valid high from that edge when FIFO was empty (latency SRAM_LAT cycles accept-to-valid). Back-to-back accepts give one response per cycle.
- FIFO: show-ahead; oRsp_data/oRsp_oob reflect head; pop on iRsp_ready & oRsp_valid. Simultaneous write and pop: count unchanged, order preserved. Credit check guarantees no overflow; write when full is impossible by construction (assertion in bench).
- Order: responses strictly in accept order, including oob ones.
- inflight counter: +1 on accept, -1 on FIFO write, unchanged when both.
- oBusy = (inflight != 0) | (fifo_count != 0).
- Coordinate widths: 13-bit inputs, product computed at 26 bits before truncation; no wrap between lines for valid coordinates.

Test Plan:
- Reset then single request X=5,Y=2 with SRAM model returning word address in DQ -> oSRAM_ADDR=1029 one cycle after accept, oRsp_valid exactly 2 cycles after accept edge, oRsp_data=1029&0x3FF=5, oRsp_oob=0.
- Stream 8 requests (X=0..7,Y=0), iRsp_ready=1 -> 8 consecutive responses data 0..7, oReq_ready never drops, one per cycle.
- iRsp_ready=0, keep iReq_valid=1 -> exactly 4 accepts, then oReq_ready=0; raise iRsp_ready -> data returns in order, ready reasserts one cycle after first pop.
- Requests (512,0), (0,384), (511,383) -> first two oob=1 data=0, third address 196607, oob=0.
- Reset asserted with 2 in flight and 2 queued -> outputs return to reset values immediately; after release no stale oRsp_valid, oBusy=0.
- Pop and write same cycle with FIFO at 3 entries -> count stays 3, order intact, oReq_ready unchanged.
